// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous DMEM between the LSU (port 0)
// and a loader/debug master (port 1), with a bounded port-1 burst lock.
module dmem_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 10,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [XLEN/8-1:0] m0_wstrb,
  output logic              m0_resp_valid,
  output logic [XLEN-1:0]   m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [XLEN/8-1:0] m1_wstrb,
  input  logic              m1_lock,
  output logic              m1_resp_valid,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv_q, rv_d;
  logic          rport_q, rport_d;
  logic          rwe_q, rwe_d;
  logic          g0, g1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    g0      = 1'b0;
    g1      = 1'b0;
    unique case (state_q)
      ARB: begin
        g0 = m0_valid & (~m1_valid | ~ptr_q);
        g1 = m1_valid & (~m0_valid | ptr_q);
        if (g0) ptr_d = 1'b1;
        if (g1) begin
          ptr_d = 1'b0;
          if (m1_lock) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end
      end
      LOCKED: begin
        g1    = m1_valid;
        cnt_d = cnt_q + CW'(1);
        // forced release bounds port-0 starvation
        if ((cnt_q == CNT_LAST) || (g1 & ~m1_lock)) begin
          state_d = ARB;
          ptr_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // reset masks grants combinationally, not only at the next edge
  assign m0_ready = g0 & rst_n;
  assign m1_ready = g1 & rst_n;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (1'b1)
      m0_ready: begin
        mem_en    = 1'b1;
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
      end
      m1_ready: begin
        mem_en    = 1'b1;
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

  always_comb begin
    rv_d    = mem_en;
    rport_d = m1_ready;
    rwe_d   = mem_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rport_q <= 1'b0;
      rwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rport_q <= rport_d;
      rwe_q   <= rwe_d;
    end
  end

  assign m0_resp_valid = rv_q & ~rport_q;
  assign m1_resp_valid = rv_q & rport_q;
  assign m0_rdata = (m0_resp_valid & ~rwe_q) ? mem_rdata : '0;
  assign m1_rdata = (m1_resp_valid & ~rwe_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, reads, contention,
// strobes, lock bound, reset mid-lock and lock release.
module tb_dmem_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 10;
  localparam int SW   = XLEN / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_valid, m0_ready, m0_we;
  logic [AW-1:0]   m0_addr;
  logic [XLEN-1:0] m0_wdata;
  logic [SW-1:0]   m0_wstrb;
  logic            m0_resp_valid;
  logic [XLEN-1:0] m0_rdata;
  logic            m1_valid, m1_ready, m1_we, m1_lock;
  logic [AW-1:0]   m1_addr;
  logic [XLEN-1:0] m1_wdata;
  logic [SW-1:0]   m1_wstrb;
  logic            m1_resp_valid;
  logic [XLEN-1:0] m1_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [SW-1:0]   mem_wstrb;
  logic [XLEN-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(XLEN), .AW(AW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_valid = 0; m0_we = 0; m0_addr = '0;
    m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_we = 0; m1_addr = '0;
    m1_wdata = '0; m1_wstrb = '0; m1_lock = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m0_valid = 1; m0_addr = 10'h00A;
    m1_valid = 1; m1_addr = 10'h00B;
    mem_rdata = 32'hA5A5_A5A5;
    step(); step();
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 00", {m0_ready, m1_ready});
    end
    n_cmp++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: en=%b addr=%h got nonzero want 0", mem_en, mem_addr);
    end
    n_cmp++;
    if ({m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_resp: rv=%b%b got nonzero want 0", m0_resp_valid, m1_resp_valid);
    end
    rst_n = 1;
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready, mem_addr} !== {2'b10, 10'h00A}) begin
      n_err++;
      $display("FAIL reset_first_grant: got rdy=%b%b addr=%h want 10 00a", m0_ready, m1_ready, mem_addr);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_strobe();
    m1_valid = 1; m1_we = 1; m1_addr = 10'h030;
    m1_wdata = 32'h1122_3344; m1_wstrb = 4'b0101;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if ({m1_ready, mem_en, mem_we, mem_wstrb, mem_wdata} !== {3'b111, 4'b0101, 32'h1122_3344}) begin
      n_err++;
      $display("FAIL strobe_pass: got rdy=%b we=%b strb=%b wdata=%h want 1 1 0101 11223344",
               m1_ready, mem_we, mem_wstrb, mem_wdata);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({m1_resp_valid, m0_resp_valid, m1_rdata} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL strobe_resp: got rv1=%b rv0=%b rdata=%h want 1 0 0", m1_resp_valid, m0_resp_valid, m1_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    int ep = 0;
    int pp = -1;
    logic [AW-1:0] ea;
    mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      m0_valid = (i0 < 4); m0_we = 1; m0_addr = AW'(32'h10 + i0);
      m0_wdata = 32'h100 + k; m0_wstrb = 4'hF;
      m1_valid = (i1 < 4); m1_we = 1; m1_addr = AW'(32'h20 + i1);
      m1_wdata = 32'h200 + k; m1_wstrb = 4'hF;
      #1;
      if (pp >= 0) begin
        n_cmp++;
        if ((pp == 0 ? {m0_resp_valid, m1_resp_valid} : {m1_resp_valid, m0_resp_valid}) !== 2'b10
            || m0_rdata !== 0 || m1_rdata !== 0) begin
          n_err++;
          $display("FAIL cont_resp%0d: got rv0=%b rv1=%b rd0=%h rd1=%h want port %0d rdata 0",
                   k, m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata, pp);
        end
      end
      ea = (ep == 0) ? AW'(32'h10 + i0) : AW'(32'h20 + i1);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr} !== {2'b11, ea}) begin
        n_err++;
        $display("FAIL cont_addr%0d: got en=%b addr=%h want 1 %h", k, mem_en, mem_addr, ea);
      end
      if (ep == 0) i0++; else i1++;
      pp = ep;
      ep ^= 1;
      step();
    end
    idle();
    #1;
    n_cmp++;
    if ({m1_resp_valid, m0_resp_valid, m1_rdata} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL cont_last_resp: got rv1=%b rv0=%b rd=%h want 1 0 0", m1_resp_valid, m0_resp_valid, m1_rdata);
    end
    step();
  endtask

  task automatic test_single_read();
    m0_valid = 1; m0_we = 0; m0_addr = 10'h004;
    mem_rdata = 32'h0;
    #1;
    n_cmp++;
    if ({m0_ready, mem_en, mem_we, mem_addr} !== {3'b110, 10'h004}) begin
      n_err++;
      $display("FAIL read_req: got rdy=%b en=%b we=%b addr=%h want 1 1 0 004", m0_ready, mem_en, mem_we, mem_addr);
    end
    step();
    idle();
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata} !== {2'b10, 32'hDEAD_BEEF, 32'h0}) begin
      n_err++;
      $display("FAIL read_resp: got rv=%b%b rd0=%h rd1=%h want 10 deadbeef 0",
               m0_resp_valid, m1_resp_valid, m0_rdata, m1_rdata);
    end
    step();
  endtask

  task automatic test_lock_bound();
    m0_valid = 1; m0_we = 0; m0_addr = 10'h050;
    m1_valid = 1; m1_we = 0; m1_addr = 10'h060; m1_lock = 1;
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL lock_enter: got rdy=%b%b want 01", m0_ready, m1_ready);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({m0_ready, m1_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL lock_hold%0d: got rdy=%b%b want 01", c, m0_ready, m1_ready);
      end
      step();
    end
    n_cmp++;
    if ({m0_ready, m1_ready, mem_addr} !== {2'b10, 10'h050}) begin
      n_err++;
      $display("FAIL lock_release: got rdy=%b%b addr=%h want 10 050", m0_ready, m1_ready, mem_addr);
    end
    step();
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL relock_grant: got rdy=%b%b want 01", m0_ready, m1_ready);
    end
    step();
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL relock_hold: got rdy=%b%b want 01", m0_ready, m1_ready);
    end
  endtask

  // entered from a LOCKED cycle with a port-1 read being accepted
  task automatic test_reset_mid_lock();
    mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({m1_resp_valid, m0_resp_valid, m1_rdata} !== {2'b00, 32'h0}) begin
      n_err++;
      $display("FAIL rst_lock_drop: got rv1=%b rv0=%b rd=%h want 0 0 0", m1_resp_valid, m0_resp_valid, m1_rdata);
    end
    n_cmp++;
    if ({m0_ready, m1_ready, mem_en} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_lock_ready: got %b want 000", {m0_ready, m1_ready, mem_en});
    end
    step();
    rst_n = 1;
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_lock_arb: got rdy=%b%b want 10", m0_ready, m1_ready);
    end
    step();
  endtask

  task automatic test_unlock();
    m0_valid = 1; m1_valid = 1; m1_lock = 1;
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL unlock_enter: got rdy=%b%b want 01", m0_ready, m1_ready);
    end
    step();
    m1_lock = 0;
    #1;
    n_cmp++;
    if ({m0_ready, m1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL unlock_beat: got rdy=%b%b want 01", m0_ready, m1_ready);
    end
    step();
    n_cmp++;
    if ({m0_ready, m1_ready, m1_resp_valid} !== 3'b101) begin
      n_err++;
      $display("FAIL unlock_exit: got rdy=%b%b rv1=%b want 10 1", m0_ready, m1_ready, m1_resp_valid);
    end
    step();
    idle();
    step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    mem_rdata = '0;
    test_reset();
    test_strobe();
    test_contention();
    test_single_read();
    test_lock_bound();
    test_reset_mid_lock();
    test_unlock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
